// File: rtl/countdown_timer.sv
// Countdown timer with prescaler, optional auto-reload and a one-cycle expiry pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not counting; o_count holds its value until start or reset
// RUN   | counting down one step per prescaler tick while i_en is high
module countdown_timer #(
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_auto,
  input  logic [WIDTH-1:0] i_reload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done
);

  // Prescaler needs at least one bit even when PRESCALE is 1 (it then stays at 0).
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic             done_q, done_n;
  logic             tick;

  assign tick = (state_q == RUN) && i_en && (presc_q == PRESC_LAST);

  // State, count, prescaler and done flag registers; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      presc_q <= presc_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic: stop beats start, start beats tick processing.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    presc_n = presc_q;
    done_n  = 1'b0;
    if (i_stop) begin
      state_n = IDLE;
      presc_n = '0;
    end else if (i_start) begin
      presc_n = '0;
      count_n = i_reload;
      if (i_reload == '0) begin
        // Zero-length countdown expires immediately without entering RUN.
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = RUN;
      end
    end else if ((state_q == RUN) && i_en) begin
      if (tick) begin
        presc_n = '0;
        if (count_q > WIDTH'(1)) begin
          count_n = count_q - WIDTH'(1);
        end else begin
          // Expiry; a zero reload value never re-arms so the timer cannot loop at 0.
          done_n = 1'b1;
          if (i_auto && (i_reload != '0)) begin
            count_n = i_reload;
          end else begin
            count_n = '0;
            state_n = IDLE;
          end
        end
      end else begin
        presc_n = presc_q + PW'(1);
      end
    end
  end

  assign o_count = count_q;
  assign o_busy  = (state_q == RUN);
  assign o_done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance with PRESCALE=1, one with PRESCALE=3.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst1, en1, start1, stop1, auto1;
  logic [9:0] reload1, count1;
  logic       busy1, done1;
  logic       rst3, en3, start3, stop3, auto3;
  logic [9:0] reload3, count3;
  logic       busy3, done3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(10), .PRESCALE(1)) u_p1 (
    .i_clk(clk), .i_rst(rst1), .i_en(en1), .i_start(start1), .i_stop(stop1),
    .i_auto(auto1), .i_reload(reload1), .o_count(count1), .o_busy(busy1), .o_done(done1)
  );

  countdown_timer #(.WIDTH(10), .PRESCALE(3)) u_p3 (
    .i_clk(clk), .i_rst(rst3), .i_en(en3), .i_start(start3), .i_stop(stop3),
    .i_auto(auto3), .i_reload(reload3), .o_count(count3), .o_busy(busy3), .o_done(done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [9:0] c, input logic b, input logic d);
    chk({tag, "_count"}, 32'(count1), 32'(c));
    chk({tag, "_busy"},  32'(busy1),  32'(b));
    chk({tag, "_done"},  32'(done1),  32'(d));
  endtask

  initial begin
    int exp3 [12] = '{2, 2, 1, 1, 1, 2, 2, 2, 1, 1, 1, 2};
    rst1 = 1'b1; en1 = 1'b1; start1 = 1'b0; stop1 = 1'b0; auto1 = 1'b0; reload1 = '0;
    rst3 = 1'b1; en3 = 1'b1; start3 = 1'b0; stop3 = 1'b0; auto3 = 1'b0; reload3 = '0;
    step();
    start1 = 1'b1; reload1 = 10'd7;          // reset must override start
    step();
    chk1("reset", 10'd0, 1'b0, 1'b0);
    chk("reset_p3_count", 32'(count3), 32'd0);
    chk("reset_p3_busy",  32'(busy3),  32'd0);
    rst1 = 1'b0; rst3 = 1'b0; start1 = 1'b0;
    step();
    chk1("idle_after_reset", 10'd0, 1'b0, 1'b0);

    // Basic countdown from 5
    reload1 = 10'd5; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk1("cd5_load", 10'd5, 1'b1, 1'b0);
    for (int k = 4; k >= 0; k--) begin
      step();
      chk1("cd5_seq", 10'(k), (k != 0), (k == 0));
    end
    step();
    chk1("cd5_after", 10'd0, 1'b0, 1'b0);

    // Enable dropped for three cycles mid-count delays expiry by three
    reload1 = 10'd4; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk1("en_load", 10'd4, 1'b1, 1'b0);
    step();
    chk1("en_3", 10'd3, 1'b1, 1'b0);
    en1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("en_frozen", 10'd3, 1'b1, 1'b0);
    end
    en1 = 1'b1;
    step();
    chk1("en_2", 10'd2, 1'b1, 1'b0);
    step();
    chk1("en_1", 10'd1, 1'b1, 1'b0);
    step();
    chk1("en_expire", 10'd0, 1'b0, 1'b1);

    // Stop and start on the same edge: stop wins, count held
    reload1 = 10'd4; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk1("ss_pre", 10'd3, 1'b1, 1'b0);
    start1 = 1'b1; stop1 = 1'b1;
    step();
    start1 = 1'b0; stop1 = 1'b0;
    chk1("ss_stop_wins", 10'd3, 1'b0, 1'b0);
    step();
    chk1("ss_idle_hold", 10'd3, 1'b0, 1'b0);

    // Start with zero reload: single done pulse, never busy
    reload1 = 10'd0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk1("zero_start", 10'd0, 1'b0, 1'b1);
    step();
    chk1("zero_after", 10'd0, 1'b0, 1'b0);

    // Restart during RUN
    reload1 = 10'd5; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk1("restart_pre", 10'd4, 1'b1, 1'b0);
    reload1 = 10'd2; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk1("restart_load", 10'd2, 1'b1, 1'b0);
    step();
    chk1("restart_1", 10'd1, 1'b1, 1'b0);
    step();
    chk1("restart_expire", 10'd0, 1'b0, 1'b1);

    // Reset mid-countdown at count 3: no done pulse
    reload1 = 10'd5; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    chk1("rstmid_pre", 10'd3, 1'b1, 1'b0);
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    chk1("rstmid", 10'd0, 1'b0, 1'b0);
    step();
    chk1("rstmid_after", 10'd0, 1'b0, 1'b0);
    reload1 = 10'd2; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk1("rstmid_restart", 10'd2, 1'b1, 1'b0);
    step();
    step();
    chk1("rstmid_expire", 10'd0, 1'b0, 1'b1);

    // Max reload with auto-reload: 1023 down to 1, then back to 1023
    auto1 = 1'b1; reload1 = 10'd1023; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk1("max_load", 10'd1023, 1'b1, 1'b0);
    for (int k = 1022; k >= 1; k--) begin
      step();
      chk("max_seq_count", 32'(count1), 32'(k));
    end
    chk1("max_at_1", 10'd1, 1'b1, 1'b0);
    step();
    chk1("max_wrap", 10'd1023, 1'b1, 1'b1);
    step();
    chk1("max_wrap_next", 10'd1022, 1'b1, 1'b0);
    stop1 = 1'b1;
    step();
    stop1 = 1'b0;
    chk1("max_stop", 10'd1022, 1'b0, 1'b0);

    // Auto-reload with zero reload value stops instead of looping at zero
    reload1 = 10'd2; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk1("az_1", 10'd1, 1'b1, 1'b0);
    reload1 = 10'd0;
    step();
    chk1("az_expire", 10'd0, 1'b0, 1'b1);
    step();
    chk1("az_after", 10'd0, 1'b0, 1'b0);
    auto1 = 1'b0;

    // PRESCALE=3, reload 2, auto: done every 6 cycles
    auto3 = 1'b1; reload3 = 10'd2; start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("p3_load_count", 32'(count3), 32'd2);
    chk("p3_load_busy",  32'(busy3),  32'd1);
    for (int s = 0; s < 12; s++) begin
      step();
      chk("p3_seq_count", 32'(count3), 32'(exp3[s]));
      chk("p3_seq_done",  32'(done3),  32'((s == 5) || (s == 11)));
      chk("p3_seq_busy",  32'(busy3),  32'd1);
    end
    // Freeze after one prescaler step; phase must resume, not restart
    step();
    chk("p3_phase1", 32'(count3), 32'd2);
    en3 = 1'b0;
    step();
    step();
    chk("p3_frozen_count", 32'(count3), 32'd2);
    chk("p3_frozen_busy",  32'(busy3),  32'd1);
    en3 = 1'b1;
    step();
    chk("p3_resume_a", 32'(count3), 32'd2);
    step();
    chk("p3_resume_b", 32'(count3), 32'd1);
    stop3 = 1'b1;
    step();
    stop3 = 1'b0;
    chk("p3_stop_busy",  32'(busy3),  32'd0);
    chk("p3_stop_count", 32'(count3), 32'd1);
    chk("p3_stop_done",  32'(done3),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 10: width of the count and reload value in bits.
REQ-002 Parameter PRESCALE, default 1: enabled clock cycles per decrement; legal range is 1 to 2^16.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_en  input  1  count enable; when low, prescaler and count SHALL hold.
REQ-006 i_start  input  1  load i_reload and begin counting down.
REQ-007 i_stop  input  1  abort the countdown and return to IDLE.
REQ-008 i_auto  input  1  auto-reload on expiry instead of stopping.
REQ-009 i_reload  input  WIDTH  start/reload value, sampled only on start and on auto-reload.
REQ-010 o_count  output  WIDTH  current count, registered.
REQ-011 o_busy  output  1  high while in RUN, registered.
REQ-012 o_done  output  1  expiry pulse, registered, exactly one cycle wide.

Function
REQ-013 The state machine SHALL have exactly two states: IDLE and RUN. o_busy SHALL be 1 in RUN and 0 in IDLE.
REQ-014 Control priority at each edge SHALL be: i_rst, then i_stop, then i_start, then tick processing.
REQ-015 Stop: i_stop=1 SHALL force IDLE, hold o_count, clear the prescaler and leave o_done at 0, from any state.
REQ-016 Start with nonzero i_reload: i_start=1 SHALL load o_count with i_reload, clear the prescaler and enter RUN on the next edge, from either state; a start during RUN restarts the countdown.
REQ-017 Start with zero i_reload: i_start=1 with i_reload=0 SHALL set o_count=0, remain in or enter IDLE, and assert o_done for one cycle on the next edge.
REQ-018 Prescaler: in RUN with i_en=1, the prescaler SHALL increment each cycle; reaching PRESCALE-1 SHALL produce a tick and wrap the prescaler to 0.
REQ-019 PRESCALE=1 SHALL tick on every enabled RUN cycle.
REQ-020 Decrement: on a tick with o_count>1, o_count SHALL decrement by 1.
REQ-021 Expiry without auto-reload: on a tick with o_count==1 and i_auto=0, o_count SHALL become 0, state SHALL become IDLE, and o_done SHALL be 1 in the same cycle.
REQ-022 Expiry with auto-reload: on a tick with o_count==1 and i_auto=1, o_count SHALL load i_reload, state SHALL stay RUN, and o_done SHALL pulse in the same cycle.
REQ-023 Auto-reload with zero i_reload: o_count SHALL become 0, state SHALL go IDLE, and o_done SHALL pulse; the timer SHALL never loop at zero.
REQ-024 Period: with auto-reload and continuous i_en, o_done SHALL pulse every reload×PRESCALE cycles.
REQ-025 Count range: o_count SHALL never wrap below 0 or exceed 2^WIDTH-1, and SHALL never change in IDLE except by start or reset.
REQ-026 i_en low in RUN SHALL freeze o_count and the prescaler with o_busy held at 1; resuming SHALL continue from the exact prescaler phase.
REQ-027 o_done SHALL never be high on two consecutive cycles unless two separate expiry events occur back to back.

Reset
REQ-028 i_rst=1 at an edge SHALL set state IDLE, o_count=0, prescaler=0, o_busy=0 and o_done=0, overriding all other inputs.
REQ-029 Reset asserted mid-countdown SHALL abandon the countdown with no o_done pulse.
REQ-030 After reset deasserts, the block SHALL idle until i_start.

Verification
REQ-031 WIDTH=10, PRESCALE=1, reload=5, auto=0, en=1, start pulse: o_count reads 5,4,3,2,1,0; o_done is high in the cycle o_count becomes 0; o_busy then falls.
REQ-032 PRESCALE=3, reload=2, auto=1: o_done pulses every 6 cycles; o_count sequence is 2,2,2,1,1,1,2...
REQ-033 Reload=4, en toggled 0 for 3 cycles mid-count: expiry is delayed by exactly 3 cycles versus REQ-031 timing.
REQ-034 Start, stop and start asserted on the same edge: stop wins (IDLE, count held); start with reload=0: o_done is a single pulse, o_busy stays 0.
REQ-035 Reset asserted when o_count=3 in RUN: next cycle o_count=0, o_busy=0, no o_done; i_start afterwards behaves as in REQ-031.
REQ-036 Reload=1023 (max), auto=1: wraps cleanly from 1 to 1023; o_count never shows 0 while in RUN.
